// File: rtl/key_debounce.sv
// key_debounce: multi-channel push-button conditioner.
//   Each raw active-low key pin is passed through a two-flop synchroniser,
//   then through an independent per-channel debounce FSM. A new level is
//   accepted only after DEB_CNT+1 consecutive identical synchronised samples.
//   Each accepted edge produces a one-cycle press (1->0) or release (0->1)
//   strobe, aligned with the key_out change.
// Ports:
//   sys_clk     : system clock (50 MHz)
//   sys_rst_n   : asynchronous reset, active-low
//   key_in      : raw key pins, active-low, asynchronous to sys_clk
//   key_out     : debounced level, active-low, registered
//   key_press   : one-cycle pulse when key_out bit goes 1->0
//   key_release : one-cycle pulse when key_out bit goes 0->1
module key_debounce #(
  parameter int unsigned          KEY_W   = 2,
  parameter int unsigned          CNT_W   = 20,
  parameter logic [CNT_W-1:0]     DEB_CNT = 20'd1000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  localparam logic [1:0] ST_UP      = 2'd0;
  localparam logic [1:0] ST_FILT_DN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_FILT_UP = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = DEB_CNT - CNT_W'(1);

  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] ksync;

  // Reset to all 1s so a reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= '1;
      ksync <= '1;
    end else begin
      sync1 <= key_in;
      ksync <= sync1;
    end
  end

  for (genvar g = 0; g < KEY_W; g++) begin : g_chan
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state     <= ST_UP;
        cnt       <= '0;
        out_q     <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          ST_UP: begin
            if (!ksync[g]) begin
              state <= ST_FILT_DN;
              cnt   <= '0;
            end
          end
          ST_FILT_DN: begin
            if (ksync[g]) begin
              state <= ST_UP;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= ST_DOWN;
              cnt     <= '0;
              out_q   <= 1'b0;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DOWN: begin
            if (ksync[g]) begin
              state <= ST_FILT_UP;
              cnt   <= '0;
            end
          end
          ST_FILT_UP: begin
            if (!ksync[g]) begin
              state <= ST_DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= ST_UP;
              cnt       <= '0;
              out_q     <= 1'b1;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ST_UP;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_out[g]     = out_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce with DEB_CNT=10.
//   A run-length model (a new level must be seen DEB+1 times in a row,
//   two cycles after it appears on the pin) is compared against the DUT on
//   every falling edge; directed scenarios add literal expectations.
module tb_key_debounce;

  localparam int DEB = 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] key_in    = 2'b11;
  logic [1:0] key_out;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  key_debounce #(
    .KEY_W  (2),
    .CNT_W  (20),
    .DEB_CNT(20'd10)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_out    (key_out),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #10 sys_clk = ~sys_clk;

  // Model: pin value reaches the filter two edges later; a channel flips
  // once it has seen DEB+1 consecutive samples differing from its level.
  logic [1:0] m_s1, m_s2, m_out, m_press, m_rel;
  int         run [2];

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_s1    <= 2'b11;
      m_s2    <= 2'b11;
      m_out   <= 2'b11;
      m_press <= 2'b00;
      m_rel   <= 2'b00;
      run[0]  <= 0;
      run[1]  <= 0;
    end else begin
      m_s1    <= key_in;
      m_s2    <= m_s1;
      m_press <= 2'b00;
      m_rel   <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (m_s2[c] != m_out[c]) begin
          if (run[c] == DEB) begin
            m_out[c] <= m_s2[c];
            if (m_s2[c]) m_rel[c]   <= 1'b1;
            else         m_press[c] <= 1'b1;
            run[c] <= 0;
          end else begin
            run[c] <= run[c] + 1;
          end
        end else begin
          run[c] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      chk("model key_out", key_out, m_out);
      chk("model key_press", key_press, m_press);
      chk("model key_release", key_release, m_rel);
    end
  end

  // Set key_in at a falling edge and keep it for n rising edges.
  task automatic hold(input logic [1:0] v, input int n);
    @(negedge sys_clk);
    key_in = v;
    repeat (n - 1) @(negedge sys_clk);
  endtask

  // Set key_in at a falling edge; the next rising edge is E.
  task automatic drive(input logic [1:0] v);
    @(negedge sys_clk);
    key_in = v;
  endtask

  // From just after drive(): stop at the falling edge following E+k.
  task automatic after_edge(input int k);
    repeat (k + 1) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int np, nr;

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("reset key_out", key_out, 2'b11);
    chk("reset key_press", key_press, 2'b00);
    chk("reset key_release", key_release, 2'b00);
    sys_rst_n = 1'b1;
    cmp_en    = 1'b1;
    repeat (5) @(negedge sys_clk);

    // 1: clean press of key0
    drive(2'b10);
    after_edge(11);
    chk("t1 out E+11", key_out, 2'b11);
    chk("t1 press E+11", key_press, 2'b00);
    @(negedge sys_clk);
    chk("t1 out E+12", key_out, 2'b10);
    chk("t1 press E+12", key_press, 2'b01);
    chk("t1 release E+12", key_release, 2'b00);
    @(negedge sys_clk);
    chk("t1 press E+13", key_press, 2'b00);
    hold(2'b11, 20);
    chk("t1 released", key_out, 2'b11);

    // 2: bounce rejection
    hold(2'b10, 5);
    hold(2'b11, 3);
    hold(2'b10, 4);
    hold(2'b11, 20);
    chk("t2 out", key_out, 2'b11);

    // 3: press, hold 100 cycles, release key1
    np = 0; nr = 0;
    @(negedge sys_clk);
    key_in = 2'b01;
    repeat (100) begin
      @(negedge sys_clk);
      np += int'(key_press[1]);
      nr += int'(key_release[1]);
    end
    chk("t3 held out", key_out, 2'b01);
    vectors++;
    if (np != 1 || nr != 0) begin
      miscompares++;
      $display("FAIL t3 strobe count: got press=%0d release=%0d expected press=1 release=0", np, nr);
    end
    key_in = 2'b11;
    after_edge(11);
    chk("t3 release E+11", key_release, 2'b00);
    chk("t3 out E+11", key_out, 2'b01);
    @(negedge sys_clk);
    chk("t3 release E+12", key_release, 2'b10);
    chk("t3 out E+12", key_out, 2'b11);
    repeat (10) @(negedge sys_clk);

    // 4: simultaneous channels
    drive(2'b00);
    after_edge(12);
    chk("t4 out", key_out, 2'b00);
    chk("t4 press", key_press, 2'b11);
    repeat (5) @(negedge sys_clk);
    drive(2'b01);
    after_edge(12);
    chk("t4 out rel0", key_out, 2'b01);
    chk("t4 release", key_release, 2'b01);
    hold(2'b11, 20);

    // 5: reset mid-filter, key held through reset
    drive(2'b10);
    after_edge(5);
    sys_rst_n = 1'b0;
    #1;
    chk("t5 out in reset", key_out, 2'b11);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    after_edge(11);
    chk("t5 out R+11", key_out, 2'b11);
    chk("t5 press R+11", key_press, 2'b00);
    @(negedge sys_clk);
    chk("t5 out R+12", key_out, 2'b10);
    chk("t5 press R+12", key_press, 2'b01);
    // reset while debounced-pressed forces released level at once
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("t5 out reset from down", key_out, 2'b11);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold(2'b11, 20);

    // 6: release glitch of DEB cycles while key0 pressed
    hold(2'b10, 20);
    chk("t6 pressed", key_out, 2'b10);
    hold(2'b11, DEB);
    hold(2'b10, 20);
    chk("t6 out", key_out, 2'b10);
    hold(2'b11, 20);
    chk("t6 final", key_out, 2'b11);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
